// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared across the LEGv8 pipeline.
//   N               - datapath and address width
//   TIMEOUT_DEFAULT - cycles the MEM stage waits for dm_ack before erroring
//   CNT_W           - width needed to count 0..TIMEOUT_DEFAULT
//   mem_state_t     - MEM stage handshake FSM states
//   is_dword_aligned- true when a byte address sits on an 8-byte boundary
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int N               = 64;
  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W           = $clog2(TIMEOUT_DEFAULT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } mem_state_t;

  function automatic logic is_dword_aligned(input logic [2:0] addr_lsb);
    return (addr_lsb == 3'b000);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// -----------------------------------------------------------------------------
// mem_timeout_counter
// Counts cycles spent waiting on the data memory and flags the cycle on which
// the count would reach LIMIT.
// Ports:
//   clk      in  clock
//   reset    in  asynchronous active-high reset
//   i_clear  in  synchronous clear (has priority over i_enable)
//   i_enable in  count this cycle
//   o_tc     out terminal count: enabled and this edge brings the count to LIMIT
// -----------------------------------------------------------------------------
module mem_timeout_counter #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // Asserted during the LIMIT-th enabled cycle, so the owner can act on the
  // same edge the count reaches LIMIT.
  assign o_tc = i_enable & (r_count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
// MEM stage of the 64-bit LEGv8 pipeline. Issues a req/ack access to a
// multi-cycle data memory, stalls the pipeline until it completes, registers
// load data for MEM/WB and produces the branch-taken select.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   valid_M                 EX/MEM holds a real instruction
//   Branch_M, zero_M        branch control and execute zero flag
//   MemRead_M, MemWrite_M   load / store
//   aluResult_M             effective byte address
//   writeData_M             store data
//   dm_ack, dm_rdata        memory completion strobe and read data
//   dm_req, dm_we           registered request and write enable
//   dm_addr, dm_wdata       registered address and store data
//   PCSrc_M                 branch taken (combinational)
//   readData_M              registered load result
//   stall_M                 freeze upstream pipeline registers
//   done_M                  one-cycle pulse when an access completes
//   mem_err                 sticky error (misalignment, bad control, timeout)
// -----------------------------------------------------------------------------
module memory_access #(
  parameter int N       = pipeline_pkg::N,
  parameter int TIMEOUT = pipeline_pkg::TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_M,
  input  logic         Branch_M,
  input  logic         zero_M,
  input  logic         MemRead_M,
  input  logic         MemWrite_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] writeData_M,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  output logic         PCSrc_M,
  output logic [N-1:0] readData_M,
  output logic         stall_M,
  output logic         done_M,
  output logic         mem_err
);

  import pipeline_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_t   r_state;
  mem_state_t   w_state_next;

  logic         r_dm_req;
  logic         r_dm_we;
  logic [N-1:0] r_dm_addr;
  logic [N-1:0] r_dm_wdata;
  logic [N-1:0] r_read_data;

  logic         w_access;
  logic         w_legal;
  logic         w_start;
  logic         w_in_wait;
  logic         w_timeout;
  logic         w_stall;
  logic         w_done;
  logic         w_err;

  assign w_access  = valid_M & (MemRead_M | MemWrite_M);
  // Legal access: doubleword aligned and exactly one of load/store.
  assign w_legal   = is_dword_aligned(aluResult_M[2:0]) & (MemRead_M ^ MemWrite_M);
  assign w_in_wait = (r_state == WAIT);
  assign w_start   = (r_state == IDLE) & w_access & w_legal;

  mem_timeout_counter #(
    .WIDTH (CW),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (~w_in_wait),
    .i_enable (w_in_wait),
    .o_tc     (w_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          // Hold the instruction in EX/MEM while it is being launched.
          w_stall      = 1'b1;
          w_state_next = w_legal ? WAIT : ERR;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        // Ack takes priority over a timeout landing on the same edge.
        if (dm_ack) begin
          w_state_next = RESP;
        end else if (w_timeout) begin
          w_state_next = ERR;
        end
      end
      RESP: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      ERR: begin
        w_stall = 1'b1;
        w_err   = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request registers: captured on launch, held through WAIT, request
  // dropped on completion or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
    end else if (w_start) begin
      r_dm_req   <= 1'b1;
      r_dm_we    <= MemWrite_M;
      r_dm_addr  <= aluResult_M;
      r_dm_wdata <= writeData_M;
    end else if (w_in_wait & (dm_ack | w_timeout)) begin
      r_dm_req   <= 1'b0;
    end
  end

  // Load data only updates on an acknowledged load; stores leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data <= '0;
    end else if (w_in_wait & dm_ack & ~r_dm_we) begin
      r_read_data <= dm_rdata;
    end
  end

  assign dm_req     = r_dm_req;
  assign dm_we      = r_dm_we;
  assign dm_addr    = r_dm_addr;
  assign dm_wdata   = r_dm_wdata;
  assign readData_M = r_read_data;
  assign stall_M    = w_stall;
  assign done_M     = w_done;
  assign mem_err    = w_err;
  assign PCSrc_M    = valid_M & Branch_M & zero_M;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_M, Branch_M, zero_M, MemRead_M, MemWrite_M;
  logic [63:0] aluResult_M, writeData_M;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        dm_req, dm_we;
  logic [63:0] dm_addr, dm_wdata;
  logic        PCSrc_M;
  logic [63:0] readData_M;
  logic        stall_M, done_M, mem_err;

  int n_assert = 0;
  int n_fail   = 0;

  memory_access dut (
    .clk         (clk),
    .reset       (reset),
    .valid_M     (valid_M),
    .Branch_M    (Branch_M),
    .zero_M      (zero_M),
    .MemRead_M   (MemRead_M),
    .MemWrite_M  (MemWrite_M),
    .aluResult_M (aluResult_M),
    .writeData_M (writeData_M),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .PCSrc_M     (PCSrc_M),
    .readData_M  (readData_M),
    .stall_M     (stall_M),
    .done_M      (done_M),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic v, input logic rd, input logic wr,
                         input logic [63:0] addr, input logic [63:0] wd);
    valid_M     = v;
    MemRead_M   = rd;
    MemWrite_M  = wr;
    aluResult_M = addr;
    writeData_M = wd;
    #1;
  endtask

  task automatic idle_inputs();
    valid_M = 0; MemRead_M = 0; MemWrite_M = 0; Branch_M = 0; zero_M = 0;
    dm_ack = 0;
    #1;
  endtask

  localparam logic [63:0] LD1 = 64'hDEADBEEF_00000001;
  localparam logic [63:0] ST1 = 64'h01234567_89ABCDEF;
  localparam logic [63:0] LD2 = 64'hA5A5A5A5_5A5A5A5A;
  localparam logic [63:0] LD3 = 64'h00000000_CAFEF00D;

  initial begin
    reset = 1; valid_M = 0; Branch_M = 0; zero_M = 0; MemRead_M = 0; MemWrite_M = 0;
    aluResult_M = 0; writeData_M = 0; dm_ack = 0; dm_rdata = 0;

    // Reset state
    tick(); tick();
    chk("rst_req", {63'd0, dm_req}, 64'd0);
    chk("rst_stall", {63'd0, stall_M}, 64'd0);
    chk("rst_done", {63'd0, done_M}, 64'd0);
    chk("rst_err", {63'd0, mem_err}, 64'd0);
    chk("rst_rdata", readData_M, 64'd0);
    reset = 0;
    tick();

    // Load at 0x40, ack in the third WAIT cycle
    present(1, 1, 0, 64'h40, 64'h0);
    chk("ld_c0_stall", {63'd0, stall_M}, 64'd1);
    chk("ld_c0_req", {63'd0, dm_req}, 64'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin dm_ack = 1; dm_rdata = LD1; #1; end
      chk($sformatf("ld_c%0d_req", c), {63'd0, dm_req}, 64'd1);
      chk($sformatf("ld_c%0d_addr", c), dm_addr, 64'h40);
      chk($sformatf("ld_c%0d_we", c), {63'd0, dm_we}, 64'd0);
      chk($sformatf("ld_c%0d_stall", c), {63'd0, stall_M}, 64'd1);
      chk($sformatf("ld_c%0d_done", c), {63'd0, done_M}, 64'd0);
    end
    tick();
    idle_inputs();
    chk("ld_resp_req", {63'd0, dm_req}, 64'd0);
    chk("ld_resp_stall", {63'd0, stall_M}, 64'd0);
    chk("ld_resp_done", {63'd0, done_M}, 64'd1);
    chk("ld_resp_rdata", readData_M, LD1);
    tick();
    chk("ld_idle_done", {63'd0, done_M}, 64'd0);
    chk("ld_idle_rdata", readData_M, LD1);

    // Store at 0x18, ack on the first request cycle
    present(1, 0, 1, 64'h18, ST1);
    chk("st_c0_stall", {63'd0, stall_M}, 64'd1);
    tick();
    dm_ack = 1; dm_rdata = LD3; #1;
    chk("st_req", {63'd0, dm_req}, 64'd1);
    chk("st_we", {63'd0, dm_we}, 64'd1);
    chk("st_addr", dm_addr, 64'h18);
    chk("st_wdata", dm_wdata, ST1);
    tick();
    idle_inputs();
    chk("st_resp_done", {63'd0, done_M}, 64'd1);
    chk("st_resp_req", {63'd0, dm_req}, 64'd0);
    chk("st_resp_rdata", readData_M, LD1);
    tick();

    // Ack while IDLE is ignored
    dm_ack = 1; dm_rdata = LD3; #1;
    tick();
    dm_ack = 0; #1;
    chk("idle_ack_done", {63'd0, done_M}, 64'd0);
    chk("idle_ack_rdata", readData_M, LD1);
    chk("idle_ack_req", {63'd0, dm_req}, 64'd0);

    // Branch select, combinational
    valid_M = 1; Branch_M = 1; zero_M = 1; #1;
    chk("br_taken", {63'd0, PCSrc_M}, 64'd1);
    chk("br_no_stall", {63'd0, stall_M}, 64'd0);
    zero_M = 0; #1;
    chk("br_zero0", {63'd0, PCSrc_M}, 64'd0);
    valid_M = 0; zero_M = 1; #1;
    chk("br_invalid", {63'd0, PCSrc_M}, 64'd0);
    idle_inputs();

    // Ack in the 16th WAIT cycle: ack beats the timeout
    present(1, 1, 0, 64'h100, 64'h0);
    tick();
    for (int c = 1; c <= 15; c++) begin
      chk($sformatf("ack16_c%0d_req", c), {63'd0, dm_req}, 64'd1);
      tick();
    end
    dm_ack = 1; dm_rdata = LD2; #1;
    chk("ack16_c16_req", {63'd0, dm_req}, 64'd1);
    tick();
    idle_inputs();
    chk("ack16_done", {63'd0, done_M}, 64'd1);
    chk("ack16_err", {63'd0, mem_err}, 64'd0);
    chk("ack16_rdata", readData_M, LD2);
    tick();

    // Reset in the second WAIT cycle of a load
    present(1, 1, 0, 64'h40, 64'h0);
    tick();
    tick();
    chk("rstw_pre_req", {63'd0, dm_req}, 64'd1);
    reset = 1; valid_M = 0; MemRead_M = 0; #1;
    chk("rstw_req", {63'd0, dm_req}, 64'd0);
    chk("rstw_stall", {63'd0, stall_M}, 64'd0);
    chk("rstw_done", {63'd0, done_M}, 64'd0);
    chk("rstw_rdata", readData_M, 64'd0);
    tick();
    reset = 0;
    tick();
    present(1, 1, 0, 64'h8, 64'h0);
    tick();
    dm_ack = 1; dm_rdata = LD3; #1;
    chk("ld8_req", {63'd0, dm_req}, 64'd1);
    chk("ld8_addr", dm_addr, 64'h8);
    tick();
    idle_inputs();
    chk("ld8_done", {63'd0, done_M}, 64'd1);
    chk("ld8_rdata", readData_M, LD3);
    tick();

    // No ack: timeout after 16 WAIT cycles
    present(1, 1, 0, 64'h200, 64'h0);
    tick();
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("to_c%0d_req", c), {63'd0, dm_req}, 64'd1);
      tick();
    end
    idle_inputs();
    chk("to_req", {63'd0, dm_req}, 64'd0);
    chk("to_err", {63'd0, mem_err}, 64'd1);
    chk("to_stall", {63'd0, stall_M}, 64'd1);
    chk("to_done", {63'd0, done_M}, 64'd0);
    dm_ack = 1; dm_rdata = LD1; #1;
    tick();
    dm_ack = 0; #1;
    chk("err_hold", {63'd0, mem_err}, 64'd1);
    chk("err_ack_rdata", readData_M, LD3);
    valid_M = 1; Branch_M = 1; zero_M = 1; #1;
    chk("err_pcsrc", {63'd0, PCSrc_M}, 64'd1);
    idle_inputs();
    reset = 1; #1;
    chk("err_rst_clear", {63'd0, mem_err}, 64'd0);
    chk("err_rst_stall", {63'd0, stall_M}, 64'd0);
    tick();
    reset = 0;
    tick();

    // Misaligned load at 0x1C
    present(1, 1, 0, 64'h1C, 64'h0);
    tick();
    idle_inputs();
    chk("mis_req", {63'd0, dm_req}, 64'd0);
    chk("mis_err", {63'd0, mem_err}, 64'd1);
    chk("mis_stall", {63'd0, stall_M}, 64'd1);
    tick(); tick();
    chk("mis_req_hold", {63'd0, dm_req}, 64'd0);
    chk("mis_err_hold", {63'd0, mem_err}, 64'd1);
    chk("mis_stall_hold", {63'd0, stall_M}, 64'd1);
    reset = 1; #1;
    chk("mis_rst_err", {63'd0, mem_err}, 64'd0);
    tick();
    reset = 0;
    tick();

    // Load and store both set: illegal
    present(1, 1, 1, 64'h10, 64'h0);
    tick();
    idle_inputs();
    chk("rdwr_req", {63'd0, dm_req}, 64'd0);
    chk("rdwr_err", {63'd0, mem_err}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
